// File: rtl/discrete_audio_pkg.sv
// Shared types and helpers for the discrete-style audio stages.
//   sample_t      : signed 16-bit audio sample
//   noise_state_e : gain envelope states of the noise gate
//   GAIN_UNITY    : gain value that passes the full amplitude
//   phase_inc()   : 32-bit phase increment for a tone/shift rate at a sample rate
package discrete_audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {SILENT, ATTACK, SUSTAIN, RELEASE} noise_state_e;

    localparam int unsigned GAIN_UNITY = 256;

    // Fraction of a full 2^32 turn advanced per sample.
    function automatic logic [31:0] phase_inc(input longint unsigned freq,
                                              input longint unsigned rate);
        longint unsigned inc;
        inc = (freq << 32) / rate;
        return inc[31:0];
    endfunction

endpackage

// File: rtl/lfsr_17.sv
// 17-bit Fibonacci LFSR, polynomial x^17 + x^14 + 1.
//   clk      : system clock
//   I_RST    : asynchronous active-high reset, loads seed (0 is replaced by 1)
//   shift_en : advance one step this clock
//   seed     : reset value
//   state    : current register contents
//   msb      : state[16], the noise bit
module lfsr_17 (
    input  logic        clk,
    input  logic        I_RST,
    input  logic        shift_en,
    input  logic [16:0] seed,
    output logic [16:0] state,
    output logic        msb
);

    logic [16:0] state_q;
    logic [16:0] state_d;
    logic [16:0] shifted;

    always_comb begin
        shifted = {state_q[15:0], state_q[16] ^ state_q[13]};
        // The all-zero state would lock the register forever; restart from 1.
        state_d = (shifted == '0) ? 17'h1 : shifted;
    end

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            state_q <= (seed == '0) ? 17'h1 : seed;
        end else if (shift_en) begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
    assign msb   = state_q[16];

endmodule

// File: rtl/lfsr_noise_source.sv
// Gated white-noise source: LFSR noise bit scaled by a ramped gain envelope.
//   clk          : system clock
//   I_RST        : asynchronous active-high reset
//   audio_clk_en : one-clk sample strobe; all state advances only on it
//   enable       : noise gate level, sampled on audio_clk_en
//   out          : registered signed noise sample, +/-AMPLITUDE*gain/256
//   lfsr_bit     : raw LFSR bit 16
module lfsr_noise_source
    import discrete_audio_pkg::*;
#(
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned NOISE_FREQ  = 12000,
    parameter int unsigned AMPLITUDE   = 8000,
    parameter int unsigned RAMP_STEP   = 8,
    parameter logic [16:0] SEED        = 17'h1
) (
    input  logic    clk,
    input  logic    I_RST,
    input  logic    audio_clk_en,
    input  logic    enable,
    output sample_t out,
    output logic    lfsr_bit
);

    localparam logic [31:0]        PHASE_INC = phase_inc(NOISE_FREQ, SAMPLE_RATE);
    localparam logic [16:0]        SEED_EFF  = (SEED == '0) ? 17'h1 : SEED;
    localparam logic [9:0]         STEP      = 10'(RAMP_STEP);
    localparam logic [9:0]         UNITY     = 10'(GAIN_UNITY);
    localparam logic signed [16:0] AMP_POS   = 17'(AMPLITUDE);
    localparam logic signed [16:0] AMP_NEG   = -AMP_POS;

    // Phase accumulator: its carry-out paces the LFSR at NOISE_FREQ.
    logic [31:0] phase_q;
    logic [31:0] phase_d;
    logic        carry;
    logic        shift_en;

    assign {carry, phase_d} = {1'b0, phase_q} + {1'b0, PHASE_INC};
    assign shift_en         = audio_clk_en & carry;

    logic [16:0] lfsr_state;
    logic        lfsr_msb;
    logic        unused_lfsr;

    lfsr_17 u_lfsr (
        .clk      (clk),
        .I_RST    (I_RST),
        .shift_en (shift_en),
        .seed     (SEED_EFF),
        .state    (lfsr_state),
        .msb      (lfsr_msb)
    );

    assign unused_lfsr = ^lfsr_state[15:0];
    assign lfsr_bit    = lfsr_msb;

    // Gain envelope FSM.
    noise_state_e state_q;
    noise_state_e state_d;
    logic [8:0]   gain_q;
    logic [8:0]   gain_d;
    logic [9:0]   gain_up;

    assign gain_up = {1'b0, gain_q} + STEP;

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            state_q <= SILENT;
        end else if (audio_clk_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SILENT:  if (enable) state_d = ATTACK;
            ATTACK: begin
                if (!enable) begin
                    state_d = RELEASE;
                end else if (gain_up >= UNITY) begin
                    state_d = SUSTAIN;
                end
            end
            SUSTAIN: if (!enable) state_d = RELEASE;
            RELEASE: begin
                if (enable) begin
                    state_d = ATTACK;
                end else if ({1'b0, gain_q} <= STEP) begin
                    state_d = SILENT;
                end
            end
            default: state_d = SILENT;
        endcase
    end

    // Saturating ramp; a gate change holds the gain for the turnaround sample.
    always_comb begin
        gain_d = gain_q;
        unique case (state_q)
            SILENT:  gain_d = '0;
            ATTACK: begin
                if (enable) begin
                    gain_d = (gain_up >= UNITY) ? UNITY[8:0] : gain_up[8:0];
                end
            end
            SUSTAIN: gain_d = UNITY[8:0];
            RELEASE: begin
                if (!enable) begin
                    gain_d = ({1'b0, gain_q} <= STEP) ? 9'd0 : gain_q - STEP[8:0];
                end
            end
            default: gain_d = '0;
        endcase
    end

    // Output scaling from pre-update lfsr and gain; |result| <= AMPLITUDE.
    logic signed [16:0] amp;
    logic signed [26:0] prod;
    sample_t            out_d;
    sample_t            out_q;

    always_comb begin
        amp   = lfsr_msb ? AMP_POS : AMP_NEG;
        prod  = 27'(amp) * 27'($signed({1'b0, gain_q}));
        out_d = sample_t'(prod >>> 8);
    end

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            phase_q <= '0;
            gain_q  <= '0;
            out_q   <= '0;
        end else if (audio_clk_en) begin
            phase_q <= phase_d;
            gain_q  <= gain_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_lfsr_noise_source.sv
module tb_lfsr_noise_source;

    localparam int          AMP        = 8000;
    localparam int          STEP       = 8;
    localparam longint      FREQ       = 12000;
    localparam longint      RATE       = 48000;
    localparam longint      TURN       = 64'h1_0000_0000;

    logic               clk;
    logic               I_RST;
    logic               audio_clk_en;
    logic               enable;
    logic signed [15:0] out;
    logic               lfsr_bit;

    lfsr_noise_source dut (
        .clk          (clk),
        .I_RST        (I_RST),
        .audio_clk_en (audio_clk_en),
        .enable       (enable),
        .out          (out),
        .lfsr_bit     (lfsr_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic signed [15:0] exp_out;
        logic               exp_bit;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: plain arithmetic on the documented rules.
    longint m_phase;
    int     m_lfsr;
    int     m_gain;
    int     m_state;  // 0 silent, 1 attack, 2 sustain, 3 release

    task automatic model_reset();
        m_phase = 0;
        m_lfsr  = 1;
        m_gain  = 0;
        m_state = 0;
    endtask

    task automatic model_step(input logic en);
        exp_t   e;
        int     amp;
        int     fb;
        longint sum;
        amp = ((m_lfsr >> 16) & 1) ? AMP : -AMP;
        e.exp_out = 16'((amp * m_gain) >>> 8);
        sum = m_phase + (FREQ * TURN) / RATE;
        if (sum >= TURN) begin
            fb = ((m_lfsr >> 16) ^ (m_lfsr >> 13)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 32'h1ffff;
            if (m_lfsr == 0) m_lfsr = 1;
        end
        m_phase = sum % TURN;
        case (m_state)
            0: begin m_gain = 0; if (en) m_state = 1; end
            1: begin
                if (!en) m_state = 3;
                else begin
                    m_gain = m_gain + STEP;
                    if (m_gain >= 256) begin m_gain = 256; m_state = 2; end
                end
            end
            2: begin m_gain = 256; if (!en) m_state = 3; end
            default: begin
                if (en) m_state = 1;
                else begin
                    m_gain = m_gain - STEP;
                    if (m_gain <= 0) begin m_gain = 0; m_state = 0; end
                end
            end
        endcase
        if (m_gain < 0 || m_gain > 256) begin
            miscompares++;
            $display("FAIL model_gain_range: got %0d, need 0..256", m_gain);
        end
        e.exp_bit = logic'((m_lfsr >> 16) & 1);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: the DUT presents a new sample after every strobe edge.
    logic strobe_seen;
    always @(posedge clk or posedge I_RST) begin
        if (I_RST) strobe_seen <= 1'b0;
        else       strobe_seen <= audio_clk_en;
    end

    always @(negedge clk) begin
        if (strobe_seen) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_underflow: got sample %0d, expected none", out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out", 32'(out), 32'(e.exp_out));
                check("lfsr_bit", {31'd0, lfsr_bit}, {31'd0, e.exp_bit});
            end
        end
    end

    // Issue one strobe, then idle for gap clocks (enable randomized while idle).
    task automatic strobe(input logic en, input int gap);
        audio_clk_en = 1'b1;
        enable       = en;
        model_step(en);
        @(posedge clk); #1;
        audio_clk_en = 1'b0;
        enable       = logic'($urandom_range(1));
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        audio_clk_en = 1'b0;
        I_RST        = 1'b1;
        #1;
        check("reset_out", 32'(out), 32'sd0);
        check("reset_lfsr_bit", {31'd0, lfsr_bit}, 32'sd0);
        @(posedge clk); #1;
        I_RST = 1'b0;
        model_reset();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    logic cur_en;

    initial begin
        I_RST        = 1'b1;
        audio_clk_en = 1'b0;
        enable       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("init_out", 32'(out), 32'sd0);
        check("init_lfsr_bit", {31'd0, lfsr_bit}, 32'sd0);
        I_RST = 1'b0;
        @(posedge clk); #1;

        // Gate closed: silence while the LFSR steps every 4th strobe.
        for (int i = 0; i < 10; i++) strobe(1'b0, 2);

        // Full attack to sustain, then release, with irregular strobe spacing.
        for (int i = 0; i < 40; i++) strobe(1'b1, $urandom_range(3));
        for (int i = 0; i < 40; i++) strobe(1'b0, $urandom_range(3));

        // Open to gain 128, then close and ramp back to silence.
        for (int i = 0; i < 17; i++) strobe(1'b1, 0);
        for (int i = 0; i < 20; i++) strobe(1'b0, 1);

        // Reset mid-attack without a strobe; next strobe must be silent.
        for (int i = 0; i < 9; i++) strobe(1'b1, 1);
        pulse_reset();
        strobe(1'b1, 1);
        strobe(1'b1, 1);

        // Random gate with occasional toggles and random spacing.
        cur_en = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(9) < 2) cur_en = ~cur_en;
            strobe(cur_en, $urandom_range(3));
            if ($urandom_range(499) == 0) pulse_reset();
        end

        // Strobe every clock, gate toggling each sample.
        for (int i = 0; i < 1000; i++) strobe(logic'(i[0]), 0);

        // Long continuous run to exercise many LFSR steps.
        for (int i = 0; i < 12000; i++) strobe(1'b1, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'sd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
